// File: rtl/reset_sequencer.sv
// Staggered per-channel reset sequencer with watchdog and instant-reset fault handling.
//
// Ports:
//   clk                 system clock
//   peripheral_aresetn  async active-low reset, the only reset in the block
//   trig_mask           per-channel: 1 = channel gated by the synchronized trigger
//   wd_mask             per-channel: 1 = channel held in reset while in FAULT
//   wd_timeout          watchdog timeout in cycles, 0 disables the watchdog
//   release_gap         cycles between consecutive channel releases
//   alive_low/high      heartbeat low/high durations in cycles
//   fault_clear         single-cycle pulse clearing a sticky fault
//   trigger_in, watchdog_in, instant_reset_in  asynchronous pins
//   ch_aresetn          registered active-low channel resets
//   reset_ack           high while in FAULT
//   alive_signal        periodic heartbeat
//   sts                 status word
module reset_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              peripheral_aresetn,
  input  logic [N_CH-1:0]   trig_mask,
  input  logic [N_CH-1:0]   wd_mask,
  input  logic [CNT_W-1:0]  wd_timeout,
  input  logic [CNT_W-1:0]  release_gap,
  input  logic [CNT_W-1:0]  alive_low,
  input  logic [CNT_W-1:0]  alive_high,
  input  logic              fault_clear,
  input  logic              trigger_in,
  input  logic              watchdog_in,
  input  logic              instant_reset_in,
  output logic [N_CH-1:0]   ch_aresetn,
  output logic              reset_ack,
  output logic              alive_signal,
  output logic [31:0]       sts
);

  localparam int unsigned IDX_W = $clog2(N_CH + 1);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);
  localparam logic [IDX_W-1:0] IdxN   = IDX_W'(N_CH);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W:0]   PerOne = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2,
    StFault   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [N_CH-1:0]     en_q, en_d;
  logic                fault_wd_q, fault_wd_d;
  logic                fault_ir_q, fault_ir_d;
  logic [N_CH-1:0]     ch_d;

  logic [1:0]              rst_sync_q;
  logic [SYNC_STAGES-1:0]  trig_ff_q, wd_ff_q, ir_ff_q;
  logic                    trig_sync, wd_sync, ir_sync, rst_done;

  logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic                wd_prev_q;
  logic                wd_expired, fault_hit;

  logic [CNT_W-1:0]    alive_cnt_q, alive_lo_q, alive_hi_q;
  logic [CNT_W:0]      alive_period;
  logic                alive_wrap, alive_q;

  assign trig_sync = trig_ff_q[SYNC_STAGES-1];
  assign wd_sync   = wd_ff_q[SYNC_STAGES-1];
  assign ir_sync   = ir_ff_q[SYNC_STAGES-1];
  // Reset release is only seen by the FSM once it has crossed two flops.
  assign rst_done  = rst_sync_q[1];

  // Watchdog: any level change restarts the count; saturate instead of wrapping.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (wd_sync != wd_prev_q) begin
      wd_cnt_d = '0;
    end else if (!(&wd_cnt_q)) begin
      wd_cnt_d = wd_cnt_q + CntOne;
    end
  end

  assign wd_expired = (wd_timeout != '0) && (wd_cnt_q >= wd_timeout);
  assign fault_hit  = ir_sync || wd_expired;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    en_d       = en_q;
    fault_wd_d = fault_wd_q;
    fault_ir_d = fault_ir_q;
    unique case (state_q)
      StHold: begin
        en_d  = '0;
        idx_d = '0;
        gap_d = '0;
        if (rst_done) state_d = StRelease;
      end
      StRelease, StRun: begin
        if (fault_hit) begin
          state_d    = StFault;
          fault_ir_d = fault_ir_q | ir_sync;
          fault_wd_d = fault_wd_q | wd_expired;
        end else if (state_q == StRelease) begin
          if (idx_q >= IdxN) begin
            state_d = StRun;
          end else if (gap_q == release_gap) begin
            for (int i = 0; i < N_CH; i++) begin
              if (idx_q == IDX_W'(i)) en_d[i] = 1'b1;
            end
            idx_d = idx_q + IdxOne;
            gap_d = '0;
            if (idx_d == IdxN) state_d = StRun;
          end else begin
            gap_d = gap_q + CntOne;
          end
        end
      end
      StFault: begin
        if (fault_clear && !fault_hit) begin
          state_d    = StHold;
          en_d       = '0;  // avoid a one-cycle release on the way back to HOLD
          fault_wd_d = 1'b0;
          fault_ir_d = 1'b0;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Masks are applied to the next-state enables so they act on the very next output.
  always_comb begin
    ch_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_d[i] = en_d[i] & (trig_mask[i] ? trig_sync : 1'b1)
                & ~((state_d == StFault) & wd_mask[i]);
    end
  end

  // Heartbeat period is latched at wrap; a zero period wraps every cycle and stays low.
  assign alive_period = {1'b0, alive_lo_q} + {1'b0, alive_hi_q};
  assign alive_wrap   = (alive_period == '0) || ({1'b0, alive_cnt_q} == alive_period - PerOne);

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      rst_sync_q  <= '0;
      trig_ff_q   <= '0;
      wd_ff_q     <= '0;
      ir_ff_q     <= '0;
      state_q     <= StHold;
      idx_q       <= '0;
      gap_q       <= '0;
      en_q        <= '0;
      fault_wd_q  <= 1'b0;
      fault_ir_q  <= 1'b0;
      ch_aresetn  <= '0;
      wd_cnt_q    <= '0;
      wd_prev_q   <= 1'b0;
      alive_cnt_q <= '0;
      alive_lo_q  <= '0;
      alive_hi_q  <= '0;
      alive_q     <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      trig_ff_q   <= {trig_ff_q[SYNC_STAGES-2:0], trigger_in};
      wd_ff_q     <= {wd_ff_q[SYNC_STAGES-2:0], watchdog_in};
      ir_ff_q     <= {ir_ff_q[SYNC_STAGES-2:0], instant_reset_in};
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      en_q        <= en_d;
      fault_wd_q  <= fault_wd_d;
      fault_ir_q  <= fault_ir_d;
      ch_aresetn  <= ch_d;
      wd_cnt_q    <= wd_cnt_d;
      wd_prev_q   <= wd_sync;
      alive_q     <= (alive_period != '0) && (alive_cnt_q >= alive_lo_q);
      if (alive_wrap) begin
        alive_cnt_q <= '0;
        alive_lo_q  <= alive_low;
        alive_hi_q  <= alive_high;
      end else begin
        alive_cnt_q <= alive_cnt_q + CntOne;
      end
    end
  end

  assign reset_ack    = (state_q == StFault);
  assign alive_signal = alive_q;

  always_comb begin
    sts            = '0;
    sts[1:0]       = state_q;
    sts[2]         = fault_wd_q;
    sts[3]         = fault_ir_q;
    sts[4]         = trig_sync;
    sts[5]         = wd_sync;
    sts[8 +: IDX_W] = idx_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  localparam int N = 4;
  localparam int W = 28;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         peripheral_aresetn = 1'b0;
  logic [N-1:0] trig_mask = '0;
  logic [N-1:0] wd_mask = '0;
  logic [W-1:0] wd_timeout = '0;
  logic [W-1:0] release_gap = W'(3);
  logic [W-1:0] alive_low = '0;
  logic [W-1:0] alive_high = '0;
  logic         fault_clear = 1'b0;
  logic         trigger_in = 1'b0;
  logic         watchdog_in = 1'b0;
  logic         instant_reset_in = 1'b0;
  logic [N-1:0] ch_aresetn;
  logic         reset_ack;
  logic         alive_signal;
  logic [31:0]  sts;

  int total = 0;
  int bad = 0;
  logic [N-1:0] exp_q[$];
  int           len_q[$];

  always #4 clk = ~clk;

  reset_sequencer #(.N_CH(N), .CNT_W(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .peripheral_aresetn(peripheral_aresetn), .trig_mask(trig_mask),
    .wd_mask(wd_mask), .wd_timeout(wd_timeout), .release_gap(release_gap),
    .alive_low(alive_low), .alive_high(alive_high), .fault_clear(fault_clear),
    .trigger_in(trigger_in), .watchdog_in(watchdog_in), .instant_reset_in(instant_reset_in),
    .ch_aresetn(ch_aresetn), .reset_ack(reset_ack), .alive_signal(alive_signal), .sts(sts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    peripheral_aresetn = 1'b0;
    repeat (5) tick();
    total++; if (ch_aresetn !== 4'b0000) begin bad++; $display("FAIL reset_ch got=%b want=0000", ch_aresetn); end
    total++; if (reset_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", reset_ack); end
    total++; if (alive_signal !== 1'b0) begin bad++; $display("FAIL reset_alive got=%b want=0", alive_signal); end
    total++; if (sts !== 32'h0) begin bad++; $display("FAIL reset_sts got=%h want=0", sts); end
    peripheral_aresetn = 1'b1;
  endtask

  // Waits for the first channel and then checks the 4-cycle staggered sequence.
  task automatic check_release(input string tag);
    int n;
    logic [N-1:0] ones;
    logic [N-1:0] exp;
    ones = 4'b1111;
    n = 0;
    while (ch_aresetn === 4'b0000 && n < 60) begin tick(); n++; end
    total++; if (ch_aresetn !== 4'b0001) begin bad++; $display("FAIL %s_first got=%b want=0001", tag, ch_aresetn); end
    for (int c = 1; c <= 12; c++) exp_q.push_back(ones >> (3 - c / 4));
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      total++; if (ch_aresetn !== exp) begin bad++; $display("FAIL %s_seq got=%b want=%b", tag, ch_aresetn, exp); end
    end
    total++; if (sts[1:0] !== 2'd2) begin bad++; $display("FAIL %s_run got=%0d want=2", tag, sts[1:0]); end
    total++; if (sts[15:8] !== 8'd4) begin bad++; $display("FAIL %s_idx got=%0d want=4", tag, sts[15:8]); end
  endtask

  task automatic test_alive_zero();
    int seen;
    seen = 0;
    repeat (20) begin tick(); if (alive_signal !== 1'b0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL alive_zero high_cycles=%0d want=0", seen); end
  endtask

  task automatic test_watchdog();
    int seen;
    wd_mask = 4'b0101;
    watchdog_in = ~watchdog_in;
    repeat (5) tick();
    wd_timeout = W'(100);
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      repeat (k == 0 ? 45 : 50) begin tick(); if (sts[1:0] === 2'd3) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL wd_toggle fault_cycles=%0d want=0", seen); end
      watchdog_in = ~watchdog_in;
    end
    repeat (103) tick();
    total++; if (sts[1:0] !== 2'd2) begin bad++; $display("FAIL wd_early got=%0d want=2", sts[1:0]); end
    tick();
    total++; if (sts[1:0] !== 2'd3) begin bad++; $display("FAIL wd_state got=%0d want=3", sts[1:0]); end
    total++; if (reset_ack !== 1'b1) begin bad++; $display("FAIL wd_ack got=%b want=1", reset_ack); end
    total++; if (sts[3:2] !== 2'b01) begin bad++; $display("FAIL wd_flags got=%b want=01", sts[3:2]); end
    total++; if (ch_aresetn !== 4'b1010) begin bad++; $display("FAIL wd_ch got=%b want=1010", ch_aresetn); end
    wd_timeout = '0;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    total++; if (sts[3:0] !== 4'b0000) begin bad++; $display("FAIL wd_clear got=%b want=0000", sts[3:0]); end
    total++; if (ch_aresetn !== 4'b0000) begin bad++; $display("FAIL wd_hold_ch got=%b want=0000", ch_aresetn); end
    check_release("wd");
  endtask

  task automatic test_instant();
    instant_reset_in = 1'b1;
    repeat (4) tick();
    total++; if (sts[3:0] !== 4'b1011) begin bad++; $display("FAIL ir_state got=%b want=1011", sts[3:0]); end
    total++; if (reset_ack !== 1'b1) begin bad++; $display("FAIL ir_ack got=%b want=1", reset_ack); end
    total++; if (ch_aresetn !== 4'b1010) begin bad++; $display("FAIL ir_ch got=%b want=1010", ch_aresetn); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
    total++; if (sts[1:0] !== 2'd3) begin bad++; $display("FAIL ir_clear_ignored got=%0d want=3", sts[1:0]); end
    instant_reset_in = 1'b0;
    repeat (4) tick();
    total++; if (sts[1:0] !== 2'd3) begin bad++; $display("FAIL ir_sticky got=%0d want=3", sts[1:0]); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    total++; if (sts[3:0] !== 4'b0000) begin bad++; $display("FAIL ir_clear got=%b want=0000", sts[3:0]); end
    check_release("ir");
  endtask

  task automatic test_trigger();
    logic [39:0] pat;
    logic [N-1:0] exp;
    pat = 40'hF0_3C_A5_0F_96;
    trigger_in = 1'b1;
    repeat (4) tick();
    trig_mask = 4'b1100;
    tick();
    total++; if (ch_aresetn !== 4'b1111) begin bad++; $display("FAIL trig_hi got=%b want=1111", ch_aresetn); end
    for (int i = 0; i < 40; i++) begin
      trigger_in = pat[i];
      exp_q.push_back({pat[i], pat[i], 2'b11});
      tick();
      if (exp_q.size() == S + 1) begin
        exp = exp_q.pop_front();
        total++; if (ch_aresetn !== exp) begin bad++; $display("FAIL trig_seq got=%b want=%b", ch_aresetn, exp); end
      end
    end
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      total++; if (ch_aresetn !== exp) begin bad++; $display("FAIL trig_drain got=%b want=%b", ch_aresetn, exp); end
    end
    trigger_in = 1'b0;
    trig_mask = 4'b0000;
    tick();
    total++; if (ch_aresetn !== 4'b1111) begin bad++; $display("FAIL trig_unmask got=%b want=1111", ch_aresetn); end
  endtask

  task automatic test_alive();
    int n;
    int exp;
    logic prev;
    bit found;
    alive_low = W'(10);
    alive_high = W'(2);
    prev = alive_signal;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (!prev && alive_signal === 1'b1) found = 1;
      prev = alive_signal;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL alive_rise got=%b want=1", found); end
    alive_high = W'(5);
    len_q.push_back(2);
    len_q.push_back(10);
    len_q.push_back(5);
    len_q.push_back(10);
    for (int ph = 0; ph < 4; ph++) begin
      n = 0;
      while (alive_signal === ((ph % 2 == 0) ? 1'b1 : 1'b0) && n < 40) begin n++; tick(); end
      exp = len_q.pop_front();
      total++; if (n !== exp) begin bad++; $display("FAIL alive_len%0d got=%0d want=%0d", ph, n, exp); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    instant_reset_in = 1'b1;
    repeat (4) tick();
    total++; if (reset_ack !== 1'b1) begin bad++; $display("FAIL arst_pre_fault got=%b want=1", reset_ack); end
    #2 peripheral_aresetn = 1'b0;
    #1;
    total++; if (reset_ack !== 1'b0) begin bad++; $display("FAIL arst_fault_ack got=%b want=0", reset_ack); end
    total++; if (sts !== 32'h0) begin bad++; $display("FAIL arst_fault_sts got=%h want=0", sts); end
    instant_reset_in = 1'b0;
    repeat (2) tick();
    peripheral_aresetn = 1'b1;
    n = 0;
    while (ch_aresetn === 4'b0000 && n < 60) begin tick(); n++; end
    tick();
    total++; if (sts[1:0] !== 2'd1) begin bad++; $display("FAIL arst_in_release got=%0d want=1", sts[1:0]); end
    #2 peripheral_aresetn = 1'b0;
    #1;
    total++; if (ch_aresetn !== 4'b0000) begin bad++; $display("FAIL arst_rel_ch got=%b want=0000", ch_aresetn); end
    total++; if (sts !== 32'h0) begin bad++; $display("FAIL arst_rel_sts got=%h want=0", sts); end
    total++; if (alive_signal !== 1'b0 || reset_ack !== 1'b0) begin
      bad++; $display("FAIL arst_rel_out got=%b%b want=00", alive_signal, reset_ack);
    end
    repeat (2) tick();
    peripheral_aresetn = 1'b1;
    check_release("arst");
  endtask

  initial begin
    test_reset();
    check_release("init");
    test_alive_zero();
    test_watchdog();
    test_instant();
    test_trigger();
    test_alive();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
